// File: rtl/addr_reg_file_ext.sv
// addr_reg_file_ext: PC/SP/AR (+extra) address register file with signed offset add,
// stride increment, sticky SP bound faults and an auto-incrementing AR burst engine.
module addr_reg_file_ext #(
    parameter int               WIDTH    = 16,
    parameter int               NUM_REGS = 4,
    parameter int               SEL_W    = $clog2(NUM_REGS),
    parameter int               STEP     = 2,
    parameter logic [WIDTH-1:0] SP_MIN   = 16'h0100,
    parameter logic [WIDTH-1:0] SP_MAX   = 16'hFFFE
) (
    input  logic                Clock,
    input  logic                rst,
    input  logic                E,
    input  logic [2:0]          FunSel,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [SEL_W-1:0]    OutCSel,
    input  logic [SEL_W-1:0]    OutDSel,
    input  logic [WIDTH-1:0]    I,
    input  logic                flag_clr,
    input  logic                burst_start,
    input  logic [7:0]          burst_len,
    input  logic                burst_adv,
    output logic [WIDTH-1:0]    OutC,
    output logic [WIDTH-1:0]    OutD,
    output logic                sp_ovf,
    output logic                sp_unf,
    output logic                burst_busy,
    output logic                burst_done
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic signed [WIDTH+1:0] ONE   = 1;
    localparam logic signed [WIDTH+1:0] STP   = (WIDTH+2)'(STEP);
    localparam logic signed [WIDTH+1:0] LO_W  = $signed({2'b00, SP_MIN});
    localparam logic signed [WIDTH+1:0] HI_W  = $signed({2'b00, SP_MAX});

    state_t                  state, state_nxt;
    logic [WIDTH-1:0]        regs [NUM_REGS];
    logic [WIDTH-1:0]        nxt  [NUM_REGS];
    logic [NUM_REGS-1:0]     we;
    logic signed [WIDTH+1:0] sp_cur, sp_off, sp_wide;
    logic                    sp_lo, sp_hi, sp_sel, ar_wr, adv, done_nxt;
    logic [7:0]              count, count_nxt;

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            case (FunSel)
                3'b000:  nxt[k] = regs[k] - WIDTH'(1);
                3'b001:  nxt[k] = regs[k] + WIDTH'(1);
                3'b010:  nxt[k] = I;
                3'b011:  nxt[k] = (k == 1) ? SP_MAX : '0;
                3'b100:  nxt[k] = regs[k] + I;
                3'b101:  nxt[k] = regs[k] + WIDTH'(STEP);
                default: nxt[k] = regs[k];
            endcase
            we[k] = E & RegSel[k];
        end
        // SP is range-checked on the unwrapped result so 0-1 reads as negative
        sp_cur = $signed({2'b00, regs[1]});
        sp_off = $signed({{2{I[WIDTH-1]}}, I});
        case (FunSel)
            3'b000:  sp_wide = sp_cur - ONE;
            3'b001:  sp_wide = sp_cur + ONE;
            3'b010:  sp_wide = $signed({2'b00, I});
            3'b011:  sp_wide = HI_W;
            3'b100:  sp_wide = sp_cur + sp_off;
            3'b101:  sp_wide = sp_cur + STP;
            default: sp_wide = sp_cur;
        endcase
        sp_lo  = sp_wide < LO_W;
        sp_hi  = sp_wide > HI_W;
        sp_sel = E & RegSel[1];
        we[1]  = sp_sel & ~sp_lo & ~sp_hi;
    end

    always_comb begin
        ar_wr     = E & RegSel[2];
        adv       = (state == BURST) & burst_adv & ~ar_wr;
        state_nxt = state;
        count_nxt = count;
        done_nxt  = 1'b0;
        if (state == IDLE) begin
            if (burst_start) begin
                count_nxt = burst_len;
                state_nxt = (burst_len == 8'd0) ? IDLE : BURST;
                done_nxt  = (burst_len == 8'd0);
            end
        end else if (adv) begin
            count_nxt = count - 8'd1;
            state_nxt = (count == 8'd1) ? IDLE : BURST;
            done_nxt  = (count == 8'd1);
        end
    end

    always_ff @(posedge Clock) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++)
                regs[k] <= (k == 1) ? SP_MAX : '0;
            sp_ovf     <= 1'b0;
            sp_unf     <= 1'b0;
            state      <= IDLE;
            count      <= 8'd0;
            burst_done <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++)
                if (we[k])
                    regs[k] <= nxt[k];
                else if (k == 2 && adv)
                    regs[k] <= regs[k] + WIDTH'(1);
            sp_ovf     <= (sp_ovf & ~flag_clr) | (sp_sel & sp_lo);
            sp_unf     <= (sp_unf & ~flag_clr) | (sp_sel & sp_hi);
            state      <= state_nxt;
            count      <= count_nxt;
            burst_done <= done_nxt;
        end
    end

    assign OutC       = (int'(OutCSel) < NUM_REGS) ? regs[OutCSel] : '0;
    assign OutD       = (int'(OutDSel) < NUM_REGS) ? regs[OutDSel] : '0;
    assign burst_busy = (state == BURST);
endmodule

// File: tb/tb_addr_reg_file_ext.sv
// tb_addr_reg_file_ext: scoreboard bench for addr_reg_file_ext; expectations are queued
// as stimulus is driven and popped when the DUT output is sampled.
module tb_addr_reg_file_ext;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SW = 2;

    logic          Clock = 1'b0;
    logic          rst, E, flag_clr, burst_start, burst_adv;
    logic [2:0]    FunSel;
    logic [N-1:0]  RegSel;
    logic [SW-1:0] OutCSel, OutDSel;
    logic [W-1:0]  I, OutC, OutD;
    logic [7:0]    burst_len;
    logic          sp_ovf, sp_unf, burst_busy, burst_done;

    int tests = 0;
    int fails = 0;

    typedef struct {logic busy; logic done; logic [W-1:0] ar;} bexp_t;
    bexp_t           bq[$];
    logic [W-1:0]    rq[$];
    logic [W+1:0]    sq[$];

    localparam logic [2:0]   SP_FS  [14] = '{3'b010, 3'b000, 3'b010, 3'b001, 3'b110, 3'b010, 3'b100,
                                             3'b100, 3'b000, 3'b111, 3'b010, 3'b010, 3'b011, 3'b101};
    localparam logic [W-1:0] SP_I   [14] = '{16'h0100, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 16'h0200, 16'hFF00,
                                             16'hFFFF, 16'h0000, 16'h0000, 16'h0050, 16'hFFFF, 16'h0000, 16'h0000};
    localparam logic         SP_CLR [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    localparam logic [W+1:0] SP_EXP [14] = '{{16'h0100, 2'b00}, {16'h0100, 2'b10}, {16'hFFFE, 2'b10},
                                             {16'hFFFE, 2'b11}, {16'hFFFE, 2'b00}, {16'h0200, 2'b00},
                                             {16'h0100, 2'b00}, {16'h0100, 2'b10}, {16'h0100, 2'b10},
                                             {16'h0100, 2'b00}, {16'h0100, 2'b10}, {16'h0100, 2'b11},
                                             {16'hFFFE, 2'b00}, {16'hFFFE, 2'b01}};

    localparam logic         BT_E   [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    localparam logic         BT_ST  [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    localparam logic         BT_ADV [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    localparam logic [7:0]   BT_LEN [8] = '{8'd4, 8'd0, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    localparam logic         BT_BSY [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    localparam logic         BT_DN  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    localparam logic [W-1:0] BT_AR  [8] = '{16'h2000, 16'h2001, 16'h3000, 16'h3000,
                                            16'h3001, 16'h3002, 16'h3003, 16'h3003};

    always #5 Clock = ~Clock;

    addr_reg_file_ext dut (
        .Clock(Clock), .rst(rst), .E(E), .FunSel(FunSel), .RegSel(RegSel),
        .OutCSel(OutCSel), .OutDSel(OutDSel), .I(I), .flag_clr(flag_clr),
        .burst_start(burst_start), .burst_len(burst_len), .burst_adv(burst_adv),
        .OutC(OutC), .OutD(OutD), .sp_ovf(sp_ovf), .sp_unf(sp_unf),
        .burst_busy(burst_busy), .burst_done(burst_done)
    );

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic op(input logic [N-1:0] sel, input logic [2:0] f, input logic [W-1:0] v);
        E = 1'b1; RegSel = sel; FunSel = f; I = v;
        tick();
        E = 1'b0;
    endtask

    task automatic test_reset;
        logic [W-1:0] exp;
        op(4'b1111, 3'b010, 16'h5555);
        op(4'b0010, 3'b010, 16'h0000);
        burst_start = 1'b1; burst_len = 8'd5; burst_adv = 1'b1;
        tick();
        burst_start = 1'b0;
        tick();
        rst = 1'b1; E = 1'b1; FunSel = 3'b010; RegSel = 4'b1111; I = 16'h1234;
        rq.push_back(16'h0000); rq.push_back(16'hFFFE); rq.push_back(16'h0000); rq.push_back(16'h0000);
        tick();
        rst = 1'b0; E = 1'b0;
        for (int k = 0; k < N; k++) begin
            OutCSel = SW'(k);
            #1;
            exp = rq.pop_front();
            tests++;
            if (OutC !== exp) begin
                fails++;
                $display("FAIL reset_reg%0d got=%h exp=%h", k, OutC, exp);
            end
        end
        tests++;
        if ({sp_ovf, sp_unf, burst_busy, burst_done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_status got=%b exp=0000", {sp_ovf, sp_unf, burst_busy, burst_done});
        end
        tick();
        tests++;
        if ({burst_busy, burst_done} !== 2'b00) begin
            fails++;
            $display("FAIL reset_no_done got=%b exp=00", {burst_busy, burst_done});
        end
        burst_adv = 1'b0;
    endtask

    task automatic test_pc_rel;
        logic [W-1:0] exp;
        OutCSel = 2'd0;
        op(4'b0001, 3'b010, 16'h0010);
        rq.push_back(16'h0008);
        op(4'b0001, 3'b100, 16'hFFF8);
        exp = rq.pop_front();
        tests++;
        if (OutC !== exp) begin
            fails++;
            $display("FAIL pc_rel got=%h exp=%h", OutC, exp);
        end
        op(4'b0001, 3'b010, 16'hFFFF);
        rq.push_back(16'h0000);
        op(4'b0001, 3'b001, 16'h0000);
        exp = rq.pop_front();
        tests++;
        if ({OutC, sp_ovf, sp_unf} !== {exp, 2'b00}) begin
            fails++;
            $display("FAIL pc_wrap got=%h/%b exp=%h/00", OutC, {sp_ovf, sp_unf}, exp);
        end
    endtask

    task automatic test_sp_guard;
        logic [W+1:0] exp;
        OutDSel = 2'd1;
        for (int k = 0; k < 14; k++) begin
            flag_clr = SP_CLR[k];
            sq.push_back(SP_EXP[k]);
            op(4'b0010, SP_FS[k], SP_I[k]);
            flag_clr = 1'b0;
            exp = sq.pop_front();
            tests++;
            if ({OutD, sp_ovf, sp_unf} !== exp) begin
                fails++;
                $display("FAIL sp_guard_%0d got=%h/%b exp=%h/%b", k, OutD, {sp_ovf, sp_unf}, exp[W+1:2], exp[1:0]);
            end
        end
    endtask

    task automatic test_multi_select;
        logic [W-1:0] exp;
        op(4'b0001, 3'b010, 16'h0010);
        op(4'b0010, 3'b010, 16'h0200);
        op(4'b0100, 3'b010, 16'h0020);
        op(4'b1000, 3'b010, 16'hABCD);
        rq.push_back(16'h0012); rq.push_back(16'h0200); rq.push_back(16'h0022); rq.push_back(16'hABCD);
        op(4'b0101, 3'b101, 16'h0000);
        for (int k = 0; k < N; k++) begin
            OutCSel = SW'(k);
            #1;
            exp = rq.pop_front();
            tests++;
            if (OutC !== exp) begin
                fails++;
                $display("FAIL multi_reg%0d got=%h exp=%h", k, OutC, exp);
            end
        end
        OutCSel = 2'd0; OutDSel = 2'd3;
        #1;
        tests++;
        if ({OutC, OutD} !== {16'h0012, 16'hABCD}) begin
            fails++;
            $display("FAIL dual_read got=%h/%h exp=0012/abcd", OutC, OutD);
        end
        op(4'b1111, 3'b011, 16'h0000);
        op(4'b0001, 3'b000, 16'h0000);
        RegSel = 4'b1111; FunSel = 3'b010; I = 16'h7777;
        tick();
        rq.push_back(16'hFFFF); rq.push_back(16'hFFFE); rq.push_back(16'h0000); rq.push_back(16'h0000);
        for (int k = 0; k < N; k++) begin
            OutCSel = SW'(k);
            #1;
            exp = rq.pop_front();
            tests++;
            if (OutC !== exp) begin
                fails++;
                $display("FAIL clear_dec_reg%0d got=%h exp=%h", k, OutC, exp);
            end
        end
    endtask

    task automatic test_burst;
        bexp_t ex;
        OutDSel = 2'd2;
        op(4'b0100, 3'b010, 16'h2000);
        burst_start = 1'b1; burst_len = 8'd4; burst_adv = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bq.push_back('{busy: c < 4, done: c == 4, ar: 16'h2000 + W'(c < 4 ? c : 4)});
            tick();
            burst_start = 1'b0;
            ex = bq.pop_front();
            tests++;
            if ({burst_busy, burst_done, OutD} !== {ex.busy, ex.done, ex.ar}) begin
                fails++;
                $display("FAIL burst4_c%0d got=%b%b/%h exp=%b%b/%h", c, burst_busy, burst_done, OutD, ex.busy, ex.done, ex.ar);
            end
        end
        burst_start = 1'b1; burst_len = 8'd0;
        for (int c = 0; c < 2; c++) begin
            bq.push_back('{busy: 1'b0, done: c == 0, ar: 16'h2004});
            tick();
            burst_start = 1'b0;
            ex = bq.pop_front();
            tests++;
            if ({burst_busy, burst_done, OutD} !== {ex.busy, ex.done, ex.ar}) begin
                fails++;
                $display("FAIL burst0_c%0d got=%b%b/%h exp=%b%b/%h", c, burst_busy, burst_done, OutD, ex.busy, ex.done, ex.ar);
            end
        end
        burst_adv = 1'b0;
    endtask

    task automatic test_back_to_back;
        bexp_t ex;
        OutDSel = 2'd2;
        op(4'b0100, 3'b010, 16'h2000);
        for (int k = 0; k < 8; k++) begin
            E = BT_E[k]; RegSel = 4'b0100; FunSel = 3'b010; I = 16'h3000;
            burst_start = BT_ST[k]; burst_len = BT_LEN[k]; burst_adv = BT_ADV[k];
            bq.push_back('{busy: BT_BSY[k], done: BT_DN[k], ar: BT_AR[k]});
            tick();
            ex = bq.pop_front();
            tests++;
            if ({burst_busy, burst_done, OutD} !== {ex.busy, ex.done, ex.ar}) begin
                fails++;
                $display("FAIL conflict_s%0d got=%b%b/%h exp=%b%b/%h", k, burst_busy, burst_done, OutD, ex.busy, ex.done, ex.ar);
            end
        end
        E = 1'b0; burst_start = 1'b0; burst_adv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; E = 1'b0; FunSel = 3'b110; RegSel = '0; I = '0; flag_clr = 1'b0;
        burst_start = 1'b0; burst_len = 8'd0; burst_adv = 1'b0; OutCSel = '0; OutDSel = '0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_pc_rel();
        test_sp_guard();
        test_multi_select();
        test_burst();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
